// File: rtl/shift_reg_univ_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_univ_if
// Purpose  : Bus bundle for the universal shift register. The master modport
//            drives the controls and the slave modport returns the status.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_reg_univ_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
);
    logic [WIDTH-1:0] parallelIn;
    logic             load;
    logic             shiftEn;
    logic             dir;
    logic             rotate;
    logic             shiftInL;
    logic             shiftInR;
    logic             start;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] regContent;
    logic             shiftOut;
    logic             busy;
    logic             done;

    modport master (
        output parallelIn, load, shiftEn, dir, rotate, shiftInL, shiftInR,
               start, count,
        input  regContent, shiftOut, busy, done
    );

    modport slave (
        input  parallelIn, load, shiftEn, dir, rotate, shiftInL, shiftInR,
               start, count,
        output regContent, shiftOut, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_univ
// Purpose  : Parametrised universal shift/rotate register with optional burst
//            sequencer, enabled by defining SHIFT_REG_UNIV_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  wire logic           c,
    input  wire logic           r,
    shift_reg_univ_if.slave     bus
);

    logic [WIDTH-1:0] r_reg;

    // One shift/rotate step; rotate recycles the exiting bit instead of the serial input.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] v,
        input logic             d,
        input logic             rot,
        input logic             inL,
        input logic             inR
    );
        logic w_in;
        if (!d) begin
            w_in = rot ? v[WIDTH-1] : inL;
            return {v[WIDTH-2:0], w_in};
        end else begin
            w_in = rot ? v[0] : inR;
            return {w_in, v[WIDTH-1:1]};
        end
    endfunction

    assign bus.regContent = r_reg;
    assign bus.shiftOut   = bus.dir ? r_reg[0] : r_reg[WIDTH-1];

`ifdef SHIFT_REG_UNIV_BURST_EN

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_dir;
    logic          r_rot;
    logic          r_busy;
    logic          r_done;

    assign bus.busy = r_busy;
    assign bus.done = r_done;

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            r_reg   <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_rot   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_reg <= bus.parallelIn;
                    end else if (bus.start) begin
                        if (bus.count != '0) begin
                            r_cnt   <= bus.count;
                            r_dir   <= bus.dir;
                            r_rot   <= bus.rotate;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (bus.shiftEn) begin
                        r_reg <= f_step(r_reg, bus.dir, bus.rotate,
                                        bus.shiftInL, bus.shiftInR);
                    end
                end
                S_RUN: begin
                    // A load aborts the burst silently: no done pulse follows.
                    if (bus.load) begin
                        r_reg   <= bus.parallelIn;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_reg <= f_step(r_reg, r_dir, r_rot,
                                        bus.shiftInL, bus.shiftInR);
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.load) begin
                        r_reg <= bus.parallelIn;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`else

    logic w_unused;
    assign w_unused = &{1'b0, bus.start, bus.count};

    assign bus.busy = 1'b0;
    assign bus.done = 1'b0;

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            r_reg <= '0;
        end else if (bus.load) begin
            r_reg <= bus.parallelIn;
        end else if (bus.shiftEn) begin
            r_reg <= f_step(r_reg, bus.dir, bus.rotate,
                            bus.shiftInL, bus.shiftInR);
        end
    end

`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_univ
// Purpose  : Scoreboard bench for shift_reg_univ (WIDTH=4, CW=4), both builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_univ;

`ifdef SHIFT_REG_UNIV_BURST_EN
    localparam bit B = 1'b1;
`else
    localparam bit B = 1'b0;
`endif

    typedef struct {
        logic [3:0] eReg;
        logic       eBusy;
        logic       eDone;
        logic       eSo;
        int         id;
    } exp_t;

    logic c;
    logic r;
    int   nChecks = 0;
    int   nFail   = 0;
    int   vecId   = 0;
    exp_t q[$];

    shift_reg_univ_if #(.WIDTH(4), .CW(4)) bus ();

    shift_reg_univ #(.WIDTH(4), .CW(4)) dut (
        .c   (c),
        .r   (r),
        .bus (bus)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s vec%0d: got %0d expected %0d", name, id, act, exp);
        end
    endtask

    task automatic chkAll(input exp_t e);
        chk("regContent", e.id, bus.regContent, e.eReg);
        chk("busy",       e.id, {3'b0, bus.busy},     {3'b0, e.eBusy});
        chk("done",       e.id, {3'b0, bus.done},     {3'b0, e.eDone});
        chk("shiftOut",   e.id, {3'b0, bus.shiftOut}, {3'b0, e.eSo});
    endtask

    // Inputs change on the falling edge; the expected post-edge state is queued.
    task automatic vec(input logic ld, input logic [3:0] pin, input logic sh,
                       input logic d, input logic rot, input logic inL, input logic inR,
                       input logic st, input logic [3:0] cnt,
                       input logic [3:0] eReg, input logic eBusy, input logic eDone,
                       input logic eSo);
        exp_t e;
        @(negedge c);
        bus.load = ld; bus.parallelIn = pin; bus.shiftEn = sh; bus.dir = d;
        bus.rotate = rot; bus.shiftInL = inL; bus.shiftInR = inR;
        bus.start = st; bus.count = cnt;
        e.eReg = eReg; e.eBusy = eBusy; e.eDone = eDone; e.eSo = eSo; e.id = vecId;
        q.push_back(e);
        vecId++;
    endtask

    task automatic idle(input logic [3:0] eReg, input logic eBusy, input logic eDone, input logic eSo);
        vec(0, 4'd0, 0, 0, 0, 0, 0, 0, 4'd0, eReg, eBusy, eDone, eSo);
    endtask

    // Monitor: compares one queued expectation after every rising edge.
    initial begin
        forever begin
            @(posedge c);
            #1;
            if (q.size() > 0) chkAll(q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        r = 1'b0;
        bus.load = 0; bus.parallelIn = 0; bus.shiftEn = 0; bus.dir = 0;
        bus.rotate = 0; bus.shiftInL = 0; bus.shiftInR = 0; bus.start = 0; bus.count = 0;
        repeat (2) @(negedge c);
        e = '{4'd0, 1'b0, 1'b0, 1'b0, -1};
        chkAll(e);
        r = 1'b1;

        // Load 7 then three left shifts
        vec(1, 4'd7, 0, 0, 0, 0, 0, 0, 4'd0, 4'd7,  0, 0, 0);
        vec(0, 4'd0, 1, 0, 0, 0, 0, 0, 4'd0, 4'd14, 0, 0, 1);
        vec(0, 4'd0, 1, 0, 0, 0, 0, 0, 4'd0, 4'd12, 0, 0, 1);
        vec(0, 4'd0, 1, 0, 0, 1, 0, 0, 4'd0, 4'd9,  0, 0, 1);
        // Right rotate, right shift, load beats shiftEn
        vec(1, 4'd9, 0, 1, 0, 0, 0, 0, 4'd0, 4'd9,  0, 0, 1);
        vec(0, 4'd0, 1, 1, 1, 0, 0, 0, 4'd0, 4'd12, 0, 0, 0);
        vec(0, 4'd0, 1, 1, 0, 0, 1, 0, 4'd0, 4'd14, 0, 0, 0);
        vec(1, 4'd3, 1, 1, 0, 0, 0, 0, 4'd0, 4'd3,  0, 0, 1);
        vec(1, 4'd6, 0, 0, 0, 0, 0, 0, 4'd0, 4'd6,  0, 0, 0);

        // Burst of 3, rotate left; start during RUN ignored, live dir only moves shiftOut
        vec(0, 4'd0, 0, 0, 1, 0, 0, 1, 4'd3, 4'd6,            B, 0, 0);
        vec(0, 4'd0, 0, 1, 0, 0, 0, 1, 4'd3, B ? 4'd12 : 4'd6, B, 0, 0);
        vec(0, 4'd0, 0, 0, 0, 0, 0, 1, 4'd3, B ? 4'd9 : 4'd6,  B, 0, B);
        idle(B ? 4'd3 : 4'd6, 0, 0, 0);
        idle(B ? 4'd3 : 4'd6, 0, B, 0);
        idle(B ? 4'd3 : 4'd6, 0, 0, 0);

        // Zero-length burst
        vec(0, 4'd0, 0, 0, 0, 0, 0, 1, 4'd0, B ? 4'd3 : 4'd6, 0, 0, 0);
        idle(B ? 4'd3 : 4'd6, 0, B, 0);
        idle(B ? 4'd3 : 4'd6, 0, 0, 0);

        // Burst of 5 aborted by load on the second step edge
        vec(0, 4'd0, 0, 0, 0, 0, 0, 1, 4'd5, B ? 4'd3 : 4'd6, B, 0, 0);
        vec(0, 4'd0, 0, 0, 0, 1, 0, 0, 4'd0, B ? 4'd7 : 4'd6, B, 0, 0);
        vec(1, 4'd10, 0, 0, 0, 0, 0, 0, 4'd0, 4'd10, 0, 0, 1);
        idle(4'd10, 0, 0, 1);
        idle(4'd10, 0, 0, 1);

        // Burst interrupted by asynchronous reset
        vec(0, 4'd0, 0, 0, 1, 0, 0, 1, 4'd5, 4'd10, B, 0, 1);
        idle(B ? 4'd5 : 4'd10, B, 0, B ? 1'b0 : 1'b1);
        @(posedge c);
        #3;
        r = 1'b0;
        #1;
        e = '{4'd0, 1'b0, 1'b0, 1'b0, 1000};
        chkAll(e);
        @(negedge c);
        @(negedge c);
        r = 1'b1;
        idle(4'd0, 0, 0, 0);
        idle(4'd0, 0, 0, 0);

        repeat (2) @(negedge c);
        nChecks++;
        if (q.size() != 0) begin
            nFail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register, the successor to the team's 4-bit parallel-in left-shift register. It adds a configurable width, left/right direction, rotate mode, and serial inputs at both ends. An optional burst sequencer shifts or rotates by a programmed count with a busy/done handshake. It sits in the datapath wherever serialisation, bit alignment or barrel-style rotation over several cycles is required.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits, minimum 2.
- `CW`, default 4: width of the burst count; maximum burst length is 2^CW-1.

Ports:
- `c`  in  1  clock; all state changes on the rising edge.
- `r`  in  1  reset, asynchronous, active-low.
- `parallelIn`  in  WIDTH  parallel load data.
- `load`  in  1  parallel load request.
- `shiftEn`  in  1  single-step shift/rotate request.
- `dir`  in  1  direction: 0 = left (toward MSB), 1 = right (toward LSB).
- `rotate`  in  1  1 = rotate (the bit shifted out re-enters at the other end), 0 = shift.
- `shiftInL`  in  1  serial bit entering the LSB on a left shift.
- `shiftInR`  in  1  serial bit entering the MSB on a right shift.
- `start`  in  1  burst start request.
- `count`  in  CW  burst length.
- `regContent`  out  WIDTH  current register value.
- `shiftOut`  out  1  bit at the exit end: MSB when `dir`=0, LSB when `dir`=1. Combinational from `regContent` and live `dir`.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse when a burst completes.

## Operation
- Reset (`r`=0), applied immediately and asynchronously:
  - `regContent`=0, `busy`=0, `done`=0.
  - Burst counter and latched mode cleared.
  - State = IDLE.
- Single-step priority when IDLE, evaluated per edge: `load` > `start` > `shiftEn` > hold.
- Step results:
  - Left shift: {reg[WIDTH-2:0], `shiftInL`}.
  - Right shift: {`shiftInR`, reg[WIDTH-1:1]}.
  - Left rotate: {reg[WIDTH-2:0], reg[WIDTH-1]}.
  - Right rotate: {reg[0], reg[WIDTH-1:1]}.
- Burst state machine, states IDLE, RUN, DONE:
  - IDLE, `start`=1, `count`=N≥1: latch N, `dir` and `rotate`; go to RUN; `busy`=1. The register is unchanged on this edge.
  - IDLE, `start`=1, `count`=0: go to DONE; register unchanged; `busy` stays 0.
  - RUN: one step per edge using the latched `dir`/`rotate`. Serial inputs are sampled live each edge. The remaining count decrements. After the step that brings it to 0, go to DONE with `busy`=0.
  - DONE: `done`=1 for exactly one cycle, then IDLE. A `start` or `shiftEn` during DONE is ignored. A `load` during DONE is honoured.
- While RUN:
  - `start` and `shiftEn` are ignored.
  - `load`=1 aborts the burst: the register loads `parallelIn`, state goes to IDLE, `busy` falls, and no `done` is issued.
- Live `dir`/`rotate` changes during RUN have no effect on the burst. They affect only `shiftOut` selection.

## Timing
- Single load or step: result visible on `regContent` after the same edge (latency 1).
- Burst of N accepted at edge k:
  - Steps occur at edges k+1 .. k+N.
  - `busy` is high from edge k to edge k+N.
  - `done` is high between edges k+N+1 and k+N+2.
  - The next `start` can be accepted at edge k+N+2.
- Zero-length burst at edge k: `done` is high between edges k+1 and k+2.
- Reset asserted mid-burst clears everything with no `done`. After release, the block is IDLE on the first edge.

## Configuration
- `SHIFT_REG_UNIV_BURST_EN` defined: the burst sequencer (IDLE/RUN/DONE, counter, latched mode) is compiled in as described above.
- Not defined: `start` and `count` are ignored, `busy` and `done` are tied to 0, and the block is a single-step universal shift register. Ports remain present in both builds.

## Test plan
All scenarios use WIDTH=4, CW=4.
- Load 7, then three left shifts with `shiftInL`=0,0,1 -> `regContent` 14, 12, 9; `shiftOut` (dir=0) reads 0,1,1,1 before each step.
- Load 9, right rotate -> 12; right shift with `shiftInR`=1 -> 14; `load` and `shiftEn` both high with `parallelIn`=3 -> 3.
- Load 6, burst with `count`=3, `dir`=0, `rotate`=1 -> values 12, 9, 3 on three successive edges. `busy` is high for 3 cycles, then `done` pulses once; `start` during RUN is ignored.
- Burst with `count`=0 -> `done` pulses one cycle later, `busy` never asserts, register unchanged.
- Burst with `count`=5 aborted by `load` with `parallelIn`=10 on the 2nd step edge -> `regContent`=10, `busy` drops, no `done`.
- Reset (`r`=0) asynchronously mid-burst -> `regContent`=0, `busy`=0, `done`=0 immediately, no clock edge needed. Build without the macro: `start`=1 has no effect.
